pcs_tx_oset_scheduler: RTL and testbench

//  Clause-36 PCS transmit sequencer: picks the ordered set sent each clock (/C/, /I/, /S/, /D/, /T/, /R/, /V/).

---
 rtl/pcs_tx_pkg.sv | 30 +++
 rtl/pcs_cfg_oset_gen.sv | 43 ++++
 rtl/pcs_tx_oset_scheduler.sv | 109 ++++++++++
 tb/tb_pcs_tx_oset_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pcs_tx_pkg.sv
// pcs_tx_pkg: shared codes and FSM states for the Clause-36 PCS transmit ordered-set scheduler.
package pcs_tx_pkg;

    localparam logic [1:0] XMIT_IDLE   = 2'd0;
    localparam logic [1:0] XMIT_CONFIG = 2'd1;
    localparam logic [1:0] XMIT_DATA   = 2'd2;

    localparam logic [7:0] OSET_I = 8'h00;
    localparam logic [7:0] OSET_C = 8'h01;
    localparam logic [7:0] OSET_S = 8'h02;
    localparam logic [7:0] OSET_D = 8'h03;
    localparam logic [7:0] OSET_T = 8'h04;
    localparam logic [7:0] OSET_R = 8'h05;
    localparam logic [7:0] OSET_V = 8'h06;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K30_7 = 8'hFE;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;

    typedef enum logic [2:0] {
        ST_IDLE_K, ST_IDLE_D, ST_CFG, ST_START, ST_DATA, ST_END_T, ST_END_R, ST_END_R2
    } state_t;

endpackage

// File: rtl/pcs_cfg_oset_gen.sv
// pcs_cfg_oset_gen: /C1/-/C2/ rotation counter and config word latch; presents the octet of the next code-group.
module pcs_cfg_oset_gen
    import pcs_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        active_i,
    input  logic        go_i,
    input  logic [15:0] cfg_i,
    output logic [7:0]  oct_o,
    output logic        k_o,
    output logic        last_o,
    output logic        wrap_o
);

    logic [2:0]  idx_q, idx_d;
    logic [15:0] word_q;

    // Entering from outside the rotation always restarts at /C1/.
    assign idx_d  = active_i ? idx_q + 3'd1 : 3'd0;
    assign k_o    = idx_d[1:0] == 2'd0;
    assign last_o = idx_d[1:0] == 2'd3;
    assign wrap_o = idx_q == 3'd7;
    assign oct_o  = idx_d[1:0] == 2'd0 ? K28_5 :
                    idx_d[1:0] == 2'd1 ? (idx_d[2] ? D2_2 : D21_5) :
                    idx_d[1:0] == 2'd2 ? word_q[7:0] : word_q[15:8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= 3'd0;
            word_q <= 16'd0;
        end else if (clr_i) begin
            idx_q  <= 3'd0;
            word_q <= 16'd0;
        end else if (go_i) begin
            idx_q <= idx_d;
            if (idx_d[1:0] == 2'd0)
                word_q <= cfg_i;
        end
    end

endmodule

// File: rtl/pcs_tx_oset_scheduler.sv
// pcs_tx_oset_scheduler: picks the ordered set and 8B code-group sent each clock,
// keeping /I/ on even boundaries and rotating /C1/-/C2/ while configuring.
module pcs_tx_oset_scheduler
    import pcs_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        power_on,
    input  logic [1:0]  xmit,
    input  logic        tx_en,
    input  logic        tx_er,
    input  logic [7:0]  txd,
    input  logic [15:0] tx_config_reg,
    input  logic        tx_disparity_pos,
    output logic [7:0]  cg_octet,
    output logic        cg_k,
    output logic        tx_even,
    output logic [7:0]  tx_o_set,
    output logic        tx_oset_indicate
);

    state_t     state_q, state_d, nxt;
    logic [7:0] oct_d, oset_d, cfg_oct;
    logic       k_d, ind_d, cfg_k, cfg_last, cfg_wrap;
    logic       data_ok;

    assign data_ok = xmit == XMIT_DATA && tx_en;

    pcs_cfg_oset_gen u_cfg (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!power_on),
        .active_i (state_q == ST_CFG),
        .go_i     (state_d == ST_CFG),
        .cfg_i    (tx_config_reg),
        .oct_o    (cfg_oct),
        .k_o      (cfg_k),
        .last_o   (cfg_last),
        .wrap_o   (cfg_wrap)
    );

    always_comb begin
        nxt = ST_IDLE_K;
        case (state_q)
            ST_IDLE_K:         nxt = ST_IDLE_D;
            ST_IDLE_D:         nxt = xmit == XMIT_CONFIG ? ST_CFG : data_ok ? ST_START : ST_IDLE_K;
            ST_CFG:            nxt = (!cfg_wrap || xmit == XMIT_CONFIG) ? ST_CFG : ST_IDLE_K;
            ST_START, ST_DATA: nxt = data_ok ? ST_DATA : ST_END_T;
            ST_END_T:          nxt = ST_END_R;
            // A /R/ on an even slot needs a second /R/ so the next /I/ starts even.
            ST_END_R:          nxt = tx_even ? ST_END_R2 : ST_IDLE_K;
            default:           nxt = ST_IDLE_K;
        endcase
        state_d = power_on ? nxt : ST_IDLE_K;
        oct_d   = K28_5;
        k_d     = 1'b1;
        oset_d  = OSET_I;
        ind_d   = 1'b1;
        case (state_d)
            ST_IDLE_K: ind_d = 1'b0;
            ST_IDLE_D: begin
                oct_d = tx_disparity_pos ? D5_6 : D16_2;
                k_d   = 1'b0;
            end
            ST_CFG: begin
                oct_d  = cfg_oct;
                k_d    = cfg_k;
                oset_d = OSET_C;
                ind_d  = cfg_last;
            end
            ST_START: begin
                oct_d  = K27_7;
                oset_d = OSET_S;
            end
            ST_DATA: begin
                oct_d  = tx_er ? K30_7 : txd;
                k_d    = tx_er;
                oset_d = tx_er ? OSET_V : OSET_D;
            end
            ST_END_T: begin
                oct_d  = K29_7;
                oset_d = OSET_T;
            end
            default: begin
                oct_d  = K23_7;
                oset_d = OSET_R;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE_K;
            cg_octet         <= K28_5;
            cg_k             <= 1'b1;
            tx_even          <= 1'b1;
            tx_o_set         <= OSET_I;
            tx_oset_indicate <= 1'b0;
        end else begin
            state_q          <= state_d;
            cg_octet         <= oct_d;
            cg_k             <= k_d;
            tx_even          <= !power_on || !tx_even;
            tx_o_set         <= oset_d;
            tx_oset_indicate <= ind_d;
        end
    end

endmodule

// File: tb/tb_pcs_tx_oset_scheduler.sv
// tb_pcs_tx_oset_scheduler: ordered-set level reference model compared every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_pcs_tx_oset_scheduler;

    logic        clk = 1'b0, rst = 1'b1, power_on = 1'b1;
    logic [1:0]  xmit = 2'd0;
    logic        tx_en = 1'b0, tx_er = 1'b0, tx_disparity_pos = 1'b0;
    logic [7:0]  txd = 8'h00;
    logic [15:0] tx_config_reg = 16'h0000;
    logic [7:0]  cg_octet, tx_o_set;
    logic        cg_k, tx_even, tx_oset_indicate;

    int n_chk = 0, n_fail = 0;
    logic run = 1'b1;

    always #5 clk = ~clk;

    pcs_tx_oset_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .power_on         (power_on),
        .xmit             (xmit),
        .tx_en            (tx_en),
        .tx_er            (tx_er),
        .txd              (txd),
        .tx_config_reg    (tx_config_reg),
        .tx_disparity_pos (tx_disparity_pos),
        .cg_octet         (cg_octet),
        .cg_k             (cg_k),
        .tx_even          (tx_even),
        .tx_o_set         (tx_o_set),
        .tx_oset_indicate (tx_oset_indicate)
    );

    // Reference: which ordered set is on the wire, how far into it, and the absolute slot number.
    localparam int S_I = 0, S_C = 1, S_S = 2, S_D = 3, S_T = 4, S_R = 5, S_V = 6;
    int          m_set, m_idx, m_pos, prev;
    logic        m_r2, done;
    logic [15:0] m_word;
    logic [7:0]  e_oct, e_oset;
    logic        e_k, e_even, e_ind;

    always @(posedge clk or negedge rst) begin
        if (!rst || !power_on) begin
            m_set = S_I; m_idx = 0; m_pos = 0; m_r2 = 1'b0;
        end else begin
            m_pos++;
            done = (m_set == S_I) ? (m_idx == 1) : (m_set == S_C) ? (m_idx == 7) : 1'b1;
            if (!done) m_idx++;
            else begin
                prev  = m_set;
                m_idx = 0;
                if (prev == S_I || prev == S_C)
                    m_set = (xmit == 2'd1) ? S_C : (prev == S_I && xmit == 2'd2 && tx_en) ? S_S : S_I;
                else if (prev == S_S || prev == S_D || prev == S_V)
                    m_set = (xmit == 2'd2 && tx_en) ? (tx_er ? S_V : S_D) : S_T;
                else if (prev == S_T) begin
                    m_set = S_R; m_r2 = 1'b0;
                end else if (!m_r2 && (m_pos - 1) % 2 == 0) begin
                    m_set = S_R; m_r2 = 1'b1;
                end else m_set = S_I;
            end
        end
        e_even = (m_pos % 2 == 0);
        e_ind  = 1'b1;
        case (m_set)
            S_I: begin
                e_oct = (m_idx == 0) ? 8'hBC : (tx_disparity_pos ? 8'hC5 : 8'h50);
                e_k = (m_idx == 0); e_oset = 8'h00; e_ind = (m_idx == 1);
            end
            S_C: begin
                if (m_idx % 4 == 0) m_word = tx_config_reg;
                e_oct = (m_idx % 4 == 0) ? 8'hBC : (m_idx % 4 == 1) ? ((m_idx == 1) ? 8'hB5 : 8'h42) :
                        (m_idx % 4 == 2) ? m_word[7:0] : m_word[15:8];
                e_k = (m_idx % 4 == 0); e_oset = 8'h01; e_ind = (m_idx % 4 == 3);
            end
            S_S: begin e_oct = 8'hFB; e_k = 1'b1; e_oset = 8'h02; end
            S_D: begin e_oct = txd;   e_k = 1'b0; e_oset = 8'h03; end
            S_V: begin e_oct = 8'hFE; e_k = 1'b1; e_oset = 8'h06; end
            S_T: begin e_oct = 8'hFD; e_k = 1'b1; e_oset = 8'h04; end
            default: begin e_oct = 8'hF7; e_k = 1'b1; e_oset = 8'h05; end
        endcase
    end

    always @(negedge clk) begin
        if (run) begin
            n_chk++;
            if ({cg_octet, cg_k, tx_even, tx_o_set, tx_oset_indicate} !== {e_oct, e_k, e_even, e_oset, e_ind}) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got oct=%h k=%b even=%b oset=%h ind=%b, want oct=%h k=%b even=%b oset=%h ind=%b",
                         $time, cg_octet, cg_k, tx_even, tx_o_set, tx_oset_indicate, e_oct, e_k, e_even, e_oset, e_ind);
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [7:0] o, input logic kk, input logic [7:0] os,
                       input logic ev, input logic ind);
        n_chk++;
        if ({cg_octet, cg_k, tx_o_set, tx_even, tx_oset_indicate} !== {o, kk, os, ev, ind}) begin
            n_fail++;
            $display("FAIL %s: got oct=%h k=%b oset=%h even=%b ind=%b, want oct=%h k=%b oset=%h even=%b ind=%b",
                     nm, cg_octet, cg_k, tx_o_set, tx_even, tx_oset_indicate, o, kk, os, ev, ind);
        end
    endtask

    task automatic wait_os(input string nm, input logic [7:0] os, input logic [7:0] o);
        int i = 0;
        while (!(tx_o_set == os && cg_octet == o) && i < 20) begin
            nxt();
            i++;
        end
        n_chk++;
        if (i >= 20) begin
            n_fail++;
            $display("FAIL %s: timeout, got oset=%h oct=%h want oset=%h oct=%h", nm, tx_o_set, cg_octet, os, o);
        end
    endtask

    logic [7:0] cfg_seq [8] = '{8'hBC, 8'hB5, 8'hA0, 8'h01, 8'hBC, 8'h42, 8'hA0, 8'h01};

    initial begin
        #1 rst = 1'b0;
        nxt();
        lit("reset", 8'hBC, 1, 8'h00, 1, 0);
        rst = 1'b1;
        nxt(); lit("idle_i2", 8'h50, 0, 8'h00, 0, 1);
        nxt(); lit("idle_k", 8'hBC, 1, 8'h00, 1, 0);
        tx_disparity_pos = 1'b1;
        nxt(); lit("idle_i1", 8'hC5, 0, 8'h00, 0, 1);
        tx_disparity_pos = 1'b0;
        nxt();
        xmit = 2'd1; tx_config_reg = 16'h01A0;
        wait_os("cfg_start", 8'h01, 8'hBC);
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 8; i++) begin
                if (r != 0 || i != 0) nxt();
                lit($sformatf("cfg%0d_%0d", r, i), cfg_seq[i], i % 4 == 0, 8'h01, i % 2 == 0, i % 4 == 3);
                if (r == 2 && i == 2) xmit = 2'd0;
            end
        nxt(); lit("cfg_exit", 8'hBC, 1, 8'h00, 1, 0);
        xmit = 2'd2; tx_en = 1'b1; txd = 8'h55;
        nxt(); lit("pre_idle", 8'h50, 0, 8'h00, 0, 1);
        txd = 8'h55; nxt(); lit("sop", 8'hFB, 1, 8'h02, 1, 1);
        txd = 8'hD5; nxt(); lit("d0", 8'hD5, 0, 8'h03, 0, 1);
        txd = 8'h11; nxt(); lit("d1", 8'h11, 0, 8'h03, 1, 1);
        txd = 8'h22; nxt(); lit("d2", 8'h22, 0, 8'h03, 0, 1);
        tx_en = 1'b0;
        nxt(); lit("t_even", 8'hFD, 1, 8'h04, 1, 1);
        nxt(); lit("r_odd", 8'hF7, 1, 8'h05, 0, 1);
        nxt(); lit("idle_after_t_even", 8'hBC, 1, 8'h00, 1, 0);
        tx_en = 1'b1; txd = 8'h55; nxt();
        txd = 8'h55; nxt();
        txd = 8'hD5; nxt();
        txd = 8'h11; nxt();
        txd = 8'h22; nxt();
        txd = 8'h33; nxt(); lit("d3", 8'h33, 0, 8'h03, 1, 1);
        tx_en = 1'b0;
        nxt(); lit("t_odd", 8'hFD, 1, 8'h04, 0, 1);
        nxt(); lit("r_even", 8'hF7, 1, 8'h05, 1, 1);
        nxt(); lit("r2", 8'hF7, 1, 8'h05, 0, 1);
        nxt(); lit("idle_after_t_odd", 8'hBC, 1, 8'h00, 1, 0);
        tx_en = 1'b1; txd = 8'h55; nxt();
        txd = 8'h55; nxt();
        txd = 8'h11; nxt();
        txd = 8'hAA; tx_er = 1'b1;
        nxt(); lit("err_v", 8'hFE, 1, 8'h06, 1, 1);
        tx_er = 1'b0; txd = 8'h33;
        nxt(); lit("post_err", 8'h33, 0, 8'h03, 0, 1);
        tx_en = 1'b0; nxt(); nxt(); nxt();
        lit("idle5", 8'hBC, 1, 8'h00, 1, 0);
        tx_en = 1'b1; txd = 8'h55; nxt();
        txd = 8'h55; nxt();
        txd = 8'h77; nxt();
        rst = 1'b0; #1;
        lit("async_rst", 8'hBC, 1, 8'h00, 1, 0);
        nxt(); rst = 1'b1;
        nxt(); nxt();
        txd = 8'h77; nxt(); lit("pre_soft", 8'h77, 0, 8'h03, 0, 1);
        power_on = 1'b0;
        nxt(); lit("soft_rst", 8'hBC, 1, 8'h00, 1, 0);
        power_on = 1'b1; tx_en = 1'b0; xmit = 2'd0;
        for (int c = 0; c < 4000; c++) begin
            nxt();
            if (!rst) rst = 1'b1;
            else if ($urandom_range(999) == 0) rst = 1'b0;
            power_on = ($urandom_range(299) != 0);
            if ($urandom_range(29) == 0) xmit = 2'($urandom_range(3));
            if ($urandom_range(5) == 0) tx_en = ~tx_en;
            tx_er = ($urandom_range(15) == 0);
            txd = 8'($urandom_range(255));
            if ($urandom_range(9) == 0) tx_config_reg = 16'($urandom_range(65535));
            tx_disparity_pos = 1'($urandom_range(1));
        end
        nxt();
        run = 1'b0;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
